// File: rtl/chess_layout_scanner_if.sv
// Square descriptor stream from the layout scanner to the LCD draw engine.
// The scanner is the master; the draw engine answers with SquareReady.
interface chess_layout_scanner_if;
   logic       SquareValid;
   logic       SquareReady;
   logic [5:0] SquareIdx;
   logic [2:0] SquareX;
   logic [2:0] SquareY;
   logic [3:0] PieceCode;
   logic       Selected;

   modport master (
      output SquareValid, SquareIdx, SquareX, SquareY,
      output PieceCode, Selected,
      input  SquareReady
   );

   modport slave (
      input  SquareValid, SquareIdx, SquareX, SquareY,
      input  PieceCode, Selected,
      output SquareReady
   );
endinterface

// File: rtl/chess_layout_scanner.sv
// Snapshots the flat board layout per frame and streams changed squares
// (or every square on a full redraw) to the draw engine.
module chess_layout_scanner (
   input  logic         clock,
   input  logic         resetApp,
   input  logic [511:0] Layout,
   input  logic         FrameStart,
   input  logic         FullRedraw,
   output logic         Busy,
   output logic         FrameDone,
   chess_layout_scanner_if.master sq
);

   typedef enum logic [1:0] {
      IDLE, SCAN, EMIT, DONE
   } state_e;

   localparam logic [5:0] LAST_IDX = 6'd63;

   state_e       state_q;
   logic [511:0] snap_q;
   logic [511:0] shadow_q;
   logic [5:0]   idx_q;
   logic         force_q;
   logic         first_q;
   logic         valid_q;
   logic [5:0]   out_idx_q;
   logic [3:0]   piece_q;
   logic         sel_q;
   logic         busy_q;
   logic         done_q;

   logic [8:0]   off;
   logic [7:0]   snap_sq;
   logic [7:0]   shad_sq;

   assign off     = {idx_q, 3'b000};
   assign snap_sq = snap_q[off +: 8];
   assign shad_sq = shadow_q[off +: 8];

   always_ff @(posedge clock) begin
      if (resetApp) begin
         state_q   <= IDLE;
         snap_q    <= '0;
         shadow_q  <= '0;
         idx_q     <= '0;
         force_q   <= 1'b0;
         first_q   <= 1'b1;
         valid_q   <= 1'b0;
         out_idx_q <= '0;
         piece_q   <= '0;
         sel_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (FrameStart) begin
                  snap_q  <= Layout;
                  force_q <= FullRedraw | first_q;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (force_q || snap_sq != shad_sq) begin
                  out_idx_q <= idx_q;
                  piece_q   <= snap_sq[3:0];
                  sel_q     <= |snap_sq[7:4];
                  valid_q   <= 1'b1;
                  state_q   <= EMIT;
               end else if (idx_q == LAST_IDX) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 6'd1;
               end
            end
            EMIT: begin
               // Descriptor is frozen until the draw engine takes it
               if (sq.SquareReady) begin
                  shadow_q[off +: 8] <= snap_sq;
                  valid_q            <= 1'b0;
                  if (idx_q == LAST_IDX) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     idx_q   <= idx_q + 6'd1;
                     state_q <= SCAN;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               first_q <= 1'b0;
               force_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sq.SquareValid = valid_q;
   assign sq.SquareIdx   = out_idx_q;
   assign sq.SquareX     = out_idx_q[2:0];
   assign sq.SquareY     = out_idx_q[5:3];
   assign sq.PieceCode   = piece_q;
   assign sq.Selected    = sel_q;
   assign Busy           = busy_q;
   assign FrameDone      = done_q;

endmodule
